// File: rtl/el2_bp_upd_pkg.sv
// ============================================================================
//  Module   : el2_bp_upd_pkg
//  Desc     : Shared types and default geometry for the BP update scheduler.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package el2_bp_upd_pkg;

  localparam int c_BTB_ADDR_LO  = 2;
  localparam int c_BTB_ADDR_HI  = 7;
  localparam int c_BTB_TAG_SIZE = 5;
  localparam int c_BP_W         = c_BTB_ADDR_HI - c_BTB_ADDR_LO + 1;
  localparam int c_BP_T         = c_BTB_TAG_SIZE;

  typedef enum logic [0:0] {
    CLR  = 1'b0,
    IDLE = 1'b1
  } bp_state_e;

  typedef struct packed {
    logic [c_BP_W-1:0] bht_addr;
    logic [1:0]        bht_data;
  } bp_fifo_ent_t;

  typedef struct packed {
    logic [c_BP_W-1:0] btb_addr;
    logic [c_BP_W-1:0] bht_addr;
    logic [c_BP_T-1:0] tag;
    logic [30:0]       tgt;
    logic              btb_vld;
    logic [1:0]        bht_data;
  } bp_ahold_t;

endpackage

`default_nettype wire

// File: rtl/el2_bp_upd_hash.sv
// ============================================================================
//  Module   : el2_bp_upd_hash
//  Desc     : Folds a branch PC (and GHR) into BTB index, BTB tag, BHT index.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module el2_bp_upd_hash
  import el2_bp_upd_pkg::*;
#(
  parameter int BTB_ADDR_LO  = c_BTB_ADDR_LO,
  parameter int BTB_ADDR_HI  = c_BTB_ADDR_HI,
  parameter int BTB_TAG_SIZE = c_BTB_TAG_SIZE
) (
  input  logic [30:0]                      pc,
  input  logic [BTB_ADDR_HI-BTB_ADDR_LO:0] ghr,
  output logic [BTB_ADDR_HI-BTB_ADDR_LO:0] idx,
  output logic [BTB_TAG_SIZE-1:0]          tag,
  output logic [BTB_ADDR_HI-BTB_ADDR_LO:0] bht_addr
);

  localparam int c_L   = BTB_ADDR_LO;
  localparam int c_W   = BTB_ADDR_HI - BTB_ADDR_LO + 1;
  localparam int c_T   = BTB_TAG_SIZE;
  localparam int c_TOP = c_L + 3*c_W + 2*c_T - 1;

  // Rebuild the byte-granular PC so slices line up with real PC bit numbers.
  logic [31:0] w_pc;
  logic        w_unused;

  assign w_pc     = {pc, 1'b0};
  assign idx      = w_pc[c_L +: c_W] ^ w_pc[c_L+c_W +: c_W] ^ w_pc[c_L+2*c_W +: c_W];
  assign tag      = w_pc[c_L+3*c_W +: c_T] ^ w_pc[c_L+3*c_W+c_T +: c_T];
  assign bht_addr = idx ^ ghr;
  assign w_unused = ^{w_pc[31:c_TOP+1], w_pc[c_L-1:0]};

endmodule

`default_nettype wire

// File: rtl/el2_bp_upd_sched.sv
// ============================================================================
//  Module   : el2_bp_upd_sched
//  Desc     : Serialises resolve (BTB+BHT) and retire (BHT) updates into one
//             BP array write slot per cycle; runs invalidate sweeps.
//  Config   : RV_BP_UPD_COALESCE_EN merges same-index retire pushes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module el2_bp_upd_sched
  import el2_bp_upd_pkg::*;
#(
  parameter int BTB_ADDR_LO  = c_BTB_ADDR_LO,
  parameter int BTB_ADDR_HI  = c_BTB_ADDR_HI,
  parameter int BTB_TAG_SIZE = c_BTB_TAG_SIZE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             a_valid,
  input  logic [30:0]                      a_pc,
  input  logic [BTB_ADDR_HI-BTB_ADDR_LO:0] a_ghr,
  input  logic [30:0]                      a_tgt,
  input  logic                             a_btb_vld,
  input  logic [1:0]                       a_bht_data,
  input  logic                             b_valid,
  output logic                             b_ready,
  input  logic [30:0]                      b_pc,
  input  logic [BTB_ADDR_HI-BTB_ADDR_LO:0] b_ghr,
  input  logic [1:0]                       b_bht_data,
  input  logic                             rd_block,
  input  logic                             clr_req,
  output logic                             wr_btb_en,
  output logic                             wr_bht_en,
  output logic [BTB_ADDR_HI-BTB_ADDR_LO:0] wr_btb_addr,
  output logic [BTB_ADDR_HI-BTB_ADDR_LO:0] wr_bht_addr,
  output logic [BTB_TAG_SIZE-1:0]          wr_tag,
  output logic [30:0]                      wr_tgt,
  output logic                             wr_btb_vld,
  output logic [1:0]                       wr_bht_data,
  output logic                             busy,
  output logic                             clr_done
);

  localparam int c_W  = BTB_ADDR_HI - BTB_ADDR_LO + 1;
  localparam int c_T  = BTB_TAG_SIZE;
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_PW + 1;

  bp_state_e       r_state;
  logic [c_W-1:0]  r_clr_cnt;
  logic            r_a_vld;
  bp_ahold_t       r_a;
  bp_fifo_ent_t    r_fifo [FIFO_DEPTH];
  logic [c_PW-1:0] r_rptr;
  logic [c_PW-1:0] r_wptr;
  logic [c_CW-1:0] r_count;

  logic [c_W-1:0]  w_a_idx;
  logic [c_T-1:0]  w_a_tag;
  logic [c_W-1:0]  w_a_bht;
  logic [c_W-1:0]  w_b_idx;
  logic [c_T-1:0]  w_b_tag;
  logic [c_W-1:0]  w_b_bht;
  logic            w_unused;
  bp_ahold_t       w_a_new;
  logic            w_a_wr;
  logic            w_b_wr;
  logic            w_push;
  logic            w_coal;
  logic            w_push_slot;

  el2_bp_upd_hash #(
    .BTB_ADDR_LO  (BTB_ADDR_LO),
    .BTB_ADDR_HI  (BTB_ADDR_HI),
    .BTB_TAG_SIZE (BTB_TAG_SIZE)
  ) u_hash_a (
    .pc       (a_pc),
    .ghr      (a_ghr),
    .idx      (w_a_idx),
    .tag      (w_a_tag),
    .bht_addr (w_a_bht)
  );

  el2_bp_upd_hash #(
    .BTB_ADDR_LO  (BTB_ADDR_LO),
    .BTB_ADDR_HI  (BTB_ADDR_HI),
    .BTB_TAG_SIZE (BTB_TAG_SIZE)
  ) u_hash_b (
    .pc       (b_pc),
    .ghr      (b_ghr),
    .idx      (w_b_idx),
    .tag      (w_b_tag),
    .bht_addr (w_b_bht)
  );

  // Retire updates only touch the BHT, so the B-side BTB hash is dropped.
  assign w_unused = ^{w_b_idx, w_b_tag};

  always_comb begin
    w_a_new          = '0;
    w_a_new.btb_addr = w_a_idx;
    w_a_new.bht_addr = w_a_bht;
    w_a_new.tag      = w_a_tag;
    w_a_new.tgt      = a_tgt;
    w_a_new.btb_vld  = a_btb_vld;
    w_a_new.bht_data = a_bht_data;
  end

  assign busy    = (r_state == CLR);
  assign b_ready = (r_count != c_CW'(FIFO_DEPTH)) && (r_state == IDLE);
  assign w_push  = b_valid && b_ready;
  assign w_a_wr  = (r_state == IDLE) && !clr_req && !rd_block && r_a_vld;
  assign w_b_wr  = (r_state == IDLE) && !clr_req && !rd_block && !r_a_vld
                   && (r_count != '0);

`ifdef RV_BP_UPD_COALESCE_EN
  logic [c_PW-1:0] w_tail;
  assign w_tail = r_wptr - 1'b1;
  // Skip the merge when the youngest entry is also the one leaving this cycle.
  assign w_coal = w_push && (r_count != '0)
                  && (r_fifo[w_tail].bht_addr == w_b_bht)
                  && !(w_b_wr && (r_count == c_CW'(1)));
`else
  assign w_coal = 1'b0;
`endif

  assign w_push_slot = w_push && !w_coal;

  always_ff @(posedge clk) begin
    if (!clr_req && w_push_slot) begin
      r_fifo[r_wptr].bht_addr <= w_b_bht;
      r_fifo[r_wptr].bht_data <= b_bht_data;
    end
`ifdef RV_BP_UPD_COALESCE_EN
    if (!clr_req && w_coal) begin
      r_fifo[w_tail].bht_data <= b_bht_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= CLR;
      r_clr_cnt   <= '0;
      r_a_vld     <= 1'b0;
      r_a         <= '0;
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      wr_btb_en   <= 1'b0;
      wr_bht_en   <= 1'b0;
      wr_btb_addr <= '0;
      wr_bht_addr <= '0;
      wr_tag      <= '0;
      wr_tgt      <= '0;
      wr_btb_vld  <= 1'b0;
      wr_bht_data <= '0;
      clr_done    <= 1'b0;
    end else begin
      wr_btb_en   <= 1'b0;
      wr_bht_en   <= 1'b0;
      wr_btb_addr <= '0;
      wr_bht_addr <= '0;
      wr_tag      <= '0;
      wr_tgt      <= '0;
      wr_btb_vld  <= 1'b0;
      wr_bht_data <= '0;
      clr_done    <= 1'b0;

      // Newest capture wins; an outgoing write carries the previous value.
      if (a_valid) begin
        r_a_vld <= 1'b1;
        r_a     <= w_a_new;
      end else if (w_a_wr) begin
        r_a_vld <= 1'b0;
      end

      case (r_state)
        CLR: begin
          if (clr_req) begin
            r_clr_cnt <= '0;
          end else if (!rd_block) begin
            wr_btb_en   <= 1'b1;
            wr_bht_en   <= 1'b1;
            wr_btb_addr <= r_clr_cnt;
            wr_bht_addr <= r_clr_cnt;
            r_clr_cnt   <= r_clr_cnt + 1'b1;
            if (&r_clr_cnt) begin
              r_state  <= IDLE;
              clr_done <= 1'b1;
            end
          end
        end
        default: begin
          if (clr_req) begin
            r_state   <= CLR;
            r_clr_cnt <= '0;
          end else if (w_a_wr) begin
            wr_btb_en   <= 1'b1;
            wr_bht_en   <= 1'b1;
            wr_btb_addr <= r_a.btb_addr;
            wr_bht_addr <= r_a.bht_addr;
            wr_tag      <= r_a.tag;
            wr_tgt      <= r_a.tgt;
            wr_btb_vld  <= r_a.btb_vld;
            wr_bht_data <= r_a.bht_data;
          end else if (w_b_wr) begin
            wr_bht_en   <= 1'b1;
            wr_bht_addr <= r_fifo[r_rptr].bht_addr;
            wr_bht_data <= r_fifo[r_rptr].bht_data;
          end
        end
      endcase

      if (clr_req) begin
        r_rptr  <= '0;
        r_wptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push_slot) r_wptr <= r_wptr + 1'b1;
        if (w_b_wr)      r_rptr <= r_rptr + 1'b1;
        case ({w_push_slot, w_b_wr})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_el2_bp_upd_sched.sv
// ============================================================================
//  Module   : tb_el2_bp_upd_sched
//  Desc     : Directed self-checking bench for el2_bp_upd_sched.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_el2_bp_upd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [30:0] a_pc;
  logic [5:0]  a_ghr;
  logic [30:0] a_tgt;
  logic        a_btb_vld;
  logic [1:0]  a_bht_data;
  logic        b_valid;
  logic        b_ready;
  logic [30:0] b_pc;
  logic [5:0]  b_ghr;
  logic [1:0]  b_bht_data;
  logic        rd_block;
  logic        clr_req;
  logic        wr_btb_en;
  logic        wr_bht_en;
  logic [5:0]  wr_btb_addr;
  logic [5:0]  wr_bht_addr;
  logic [4:0]  wr_tag;
  logic [30:0] wr_tgt;
  logic        wr_btb_vld;
  logic [1:0]  wr_bht_data;
  logic        busy;
  logic        clr_done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef RV_BP_UPD_COALESCE_EN
  localparam bit c_COAL = 1'b1;
`else
  localparam bit c_COAL = 1'b0;
`endif

  el2_bp_upd_sched u_dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_pc        (a_pc),
    .a_ghr       (a_ghr),
    .a_tgt       (a_tgt),
    .a_btb_vld   (a_btb_vld),
    .a_bht_data  (a_bht_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_pc        (b_pc),
    .b_ghr       (b_ghr),
    .b_bht_data  (b_bht_data),
    .rd_block    (rd_block),
    .clr_req     (clr_req),
    .wr_btb_en   (wr_btb_en),
    .wr_bht_en   (wr_bht_en),
    .wr_btb_addr (wr_btb_addr),
    .wr_bht_addr (wr_bht_addr),
    .wr_tag      (wr_tag),
    .wr_tgt      (wr_tgt),
    .wr_btb_vld  (wr_btb_vld),
    .wr_bht_data (wr_bht_data),
    .busy        (busy),
    .clr_done    (clr_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [52:0] a_word();
    return {wr_btb_en, wr_bht_en, wr_btb_addr, wr_bht_addr, wr_tag, wr_tgt, wr_btb_vld, wr_bht_data};
  endfunction

  function automatic logic [9:0] b_word();
    return {wr_btb_en, wr_bht_en, wr_bht_addr, wr_bht_data};
  endfunction

  // 64 clear writes at 0..63; optional single blocked cycle before index blk_at.
  task automatic sweep_check(input int blk_at);
    for (int i = 0; i < 64; i++) begin
      if (i == blk_at) begin
        rd_block = 1'b1;
        tick();
        check_val("sweep_blocked", {wr_btb_en, wr_bht_en}, 2'b00);
        rd_block = 1'b0;
      end
      tick();
      check_val("sweep_wr",
                {busy, wr_btb_en, wr_bht_en, wr_btb_addr, wr_bht_addr, wr_tag,
                 wr_btb_vld, wr_bht_data, wr_tgt, clr_done},
                {(i != 63), 1'b1, 1'b1, 6'(i), 6'(i), 5'd0, 1'b0, 2'd0, 31'd0, (i == 63)});
    end
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_pc = '0; a_ghr = '0; a_tgt = '0; a_btb_vld = 1'b0; a_bht_data = '0;
    b_valid = 1'b0; b_pc = '0; b_ghr = '0; b_bht_data = '0;
    rd_block = 1'b0; clr_req = 1'b0;

    repeat (3) tick();
    check_val("reset_state", {busy, b_ready, wr_btb_en, wr_bht_en, clr_done}, 5'b10000);
    rst = 1'b0;

    sweep_check(-1);
    check_val("post_sweep", {busy, b_ready}, 2'b01);
    tick();
    check_val("idle_quiet", {wr_btb_en, wr_bht_en, clr_done}, 3'b000);

    // A update, PC 0x104: idx = 1^1 = 0, bht = 0^5 = 5, tag 0
    a_valid = 1'b1; a_pc = 31'h82; a_ghr = 6'h05; a_tgt = 31'h100;
    a_btb_vld = 1'b1; a_bht_data = 2'b11;
    tick();
    a_valid = 1'b0;
    check_val("a1_latency", {wr_btb_en, wr_bht_en}, 2'b00);
    tick();
    check_val("a1_write", 64'(a_word()),
              64'({1'b1, 1'b1, 6'h00, 6'h05, 5'h00, 31'h100, 1'b1, 2'b11}));

    // A update, PC 0xD3C4FA8: idx = 2A^0F^31 = 14, tag = 13^06 = 15, bht = 14^3F = 2B
    a_valid = 1'b1; a_pc = 31'h69E27D4; a_ghr = 6'h3F; a_tgt = 31'h1234;
    a_btb_vld = 1'b0; a_bht_data = 2'b01;
    tick();
    a_valid = 1'b0;
    tick();
    check_val("a2_write", 64'(a_word()),
              64'({1'b1, 1'b1, 6'h14, 6'h2B, 5'h15, 31'h1234, 1'b0, 2'b01}));

    // A and B pending together under two blocked cycles
    rd_block = 1'b1;
    a_valid = 1'b1; a_pc = 31'h82; a_ghr = 6'h0A; a_tgt = 31'h40;
    a_btb_vld = 1'b1; a_bht_data = 2'b01;
    b_valid = 1'b1; b_pc = 31'h82; b_ghr = 6'h11; b_bht_data = 2'b10;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
    check_val("blk_cycle1", {wr_btb_en, wr_bht_en}, 2'b00);
    tick();
    check_val("blk_cycle2", {wr_btb_en, wr_bht_en}, 2'b00);
    rd_block = 1'b0;
    tick();
    check_val("arb_a_first", 64'(a_word()),
              64'({1'b1, 1'b1, 6'h00, 6'h0A, 5'h00, 31'h40, 1'b1, 2'b01}));
    tick();
    check_val("arb_b_second", 64'(b_word()), 64'({1'b0, 1'b1, 6'h11, 2'b10}));
    tick();
    check_val("arb_drained", {wr_btb_en, wr_bht_en}, 2'b00);

    // Fill the retire queue while blocked
    rd_block = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1; b_pc = 31'h82; b_ghr = 6'(i + 1); b_bht_data = 2'(i + 1);
      check_val("fill_ready", b_ready, 1'b1);
      tick();
    end
    b_ghr = 6'h07; b_bht_data = 2'b11;
    check_val("full_not_ready", b_ready, 1'b0);
    tick();
    b_valid = 1'b0;
    rd_block = 1'b0;
    tick();
    check_val("fifo_wr0", 64'(b_word()), 64'({1'b0, 1'b1, 6'h01, 2'b01}));
    check_val("ready_after_pop", b_ready, 1'b1);
    tick();
    check_val("fifo_wr1", 64'(b_word()), 64'({1'b0, 1'b1, 6'h02, 2'b10}));
    tick();
    check_val("fifo_wr2", 64'(b_word()), 64'({1'b0, 1'b1, 6'h03, 2'b11}));
    tick();
    check_val("fifo_wr3", 64'(b_word()), 64'({1'b0, 1'b1, 6'h04, 2'b00}));
    tick();
    check_val("fifo_no_overflow", {wr_btb_en, wr_bht_en}, 2'b00);

    // Two pushes to the same BHT index
    rd_block = 1'b1;
    b_valid = 1'b1; b_pc = 31'h82; b_ghr = 6'h09; b_bht_data = 2'b01;
    tick();
    b_bht_data = 2'b10;
    tick();
    b_valid = 1'b0;
    rd_block = 1'b0;
    tick();
    check_val("coal_wr0", 64'(b_word()),
              64'({1'b0, 1'b1, 6'h09, (c_COAL ? 2'b10 : 2'b01)}));
    tick();
    check_val("coal_wr1", 64'(b_word()),
              64'(c_COAL ? 10'd0 : {1'b0, 1'b1, 6'h09, 2'b10}));
    tick();
    check_val("coal_idle", {wr_btb_en, wr_bht_en}, 2'b00);

    // clr_req with two queued entries, then a restart mid-sweep
    rd_block = 1'b1;
    b_valid = 1'b1; b_ghr = 6'h14; b_bht_data = 2'b01;
    tick();
    b_ghr = 6'h15; b_bht_data = 2'b10;
    tick();
    b_valid = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check_val("clr_enter", {busy, b_ready, wr_btb_en, wr_bht_en}, 4'b1000);
    rd_block = 1'b0;
    repeat (10) tick();
    check_val("sweep_mid", {wr_btb_en, wr_btb_addr}, {1'b1, 6'd9});
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    sweep_check(32);
    check_val("clr_exit", {busy, b_ready}, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("fifo_flushed", {wr_btb_en, wr_bht_en}, 2'b00);
    end

    // Asynchronous reset in the middle of a sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    check_val("async_reset", {busy, wr_btb_en, wr_bht_en, clr_done, b_ready}, 5'b10000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sweep_check(-1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
